writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Drives the register bank's single write port (enc, addrc, datac) from two pipeline writeback sources: ALU results and memory load results.
- When both sources present a write in the same cycle, the younger one is buffered in a small in-order FIFO and committed in later cycles.
- Exports pending-write flags for two read addresses, used by hazard detection, plus a stall to upstream when buffer space is low.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load writeback request (older than same-cycle ALU request)
- mem_addr  in  5  load destination register
- mem_data  in  32  load data
- qa  in  5  hazard query address A
- qb  in  5  hazard query address B
- enc  out  1  register bank write enable (registered)
- addrc  out  5  register bank write address (registered)
- datac  out  32  register bank write data (registered)
- pend_a  out  1  write to qa still outstanding (combinational)
- pend_b  out  1  write to qb still outstanding (combinational)
- stall  out  1  upstream must hold valids low next cycle
- overflow  out  1  sticky: a request was dropped
- count  out  PTR_W+1  FIFO occupancy

Behaviour:
- Reset (sync, any cycle, including mid-drain):
  - FIFO emptied, count=0.
  - enc=0, addrc=0, datac=0, overflow=0.
  - Buffered writes are discarded.
- Filtering: a request with addr=0 is treated as not valid. It is never buffered, committed or flagged pending.
- Age order, oldest first: FIFO head, then mem, then alu.
- Each cycle, the oldest valid item is selected for commit. It appears on enc/addrc/datac at the next rising edge; latency is 1 cycle from request to enc high.
- Remaining same-cycle requests are pushed into the FIFO in age order (mem before alu).
- FIFO pop and up to two pushes occur in the same cycle; count updates as count − pop + pushes.
- No valid item selected → enc=0 next cycle; addrc and datac hold their previous values.
- Ordering guarantee: writes to the same address commit in age order, so the last write wins in the bank.
- stall = (count ≥ DEPTH−1), combinational from count.
- Overflow: if a push would exceed DEPTH entries, the alu item is dropped first, then the mem item; overflow is set and stays high until reset.
- Pending flags: pend_a=1 iff qa≠0 and qa equals any of:
  - a valid FIFO entry's address,
  - a filtered-valid mem_addr or alu_addr this cycle,
  - addrc while enc=1.
- pend_b is the same for qb.
- The enc/addrc term exists because the bank samples reads and writes on the same edge, so reads return the old value.
- Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.

Test Plan:
- Reset: hold reset 2 cycles with alu_valid=1 → enc=0, addrc=0, datac=0, count=0, overflow=0, stall=0.
- Single write: alu_valid=1, alu_addr=5, alu_data=0x0000_00AA for 1 cycle → next cycle enc=1, addrc=5, datac=0xAA; following cycle enc=0.
- Collision:
  - Stimulus: mem(3, 0x111) and alu(3, 0x222) in the same cycle.
  - Response: commits (3, 0x111) then (3, 0x222) on consecutive cycles.
  - pend_a (qa=3) is 1 through the second commit cycle and 0 after.
- Zero register: mem(0, 0xDEAD) with alu(7, 0x7) → single commit (7, 0x7); count stays 0; pend_a with qa=0 stays 0 throughout.
- Fill/stall with DEPTH=4:
  - Stimulus: dual requests on 3 consecutive cycles.
  - Response: count goes 1, 2, 3 and stall asserts when count=3.
  - After dropping valids, 3 more commits in FIFO order; count returns to 0.
- Overflow/reset:
  - Stimulus: keep dual requests while stall=1.
  - Response: overflow goes 1 when count would exceed 4, and the alu item is dropped.
  - Assert reset mid-drain → next cycle enc=0, count=0, overflow=0; no further commits.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-bank write port.
// Same-cycle losers are buffered in an in-order FIFO; commit order always follows age.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_addr,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  input  logic [4:0]       mem_addr,
  input  logic [31:0]      mem_data,
  input  logic [4:0]       qa,
  input  logic [4:0]       qb,
  output logic             enc,
  output logic [4:0]       addrc,
  output logic [31:0]      datac,
  output logic             pend_a,
  output logic             pend_b,
  output logic             stall,
  output logic             overflow,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CntW = PTR_W + 1;

  logic [4:0]       fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, wr_ptr_p1;
  logic [PTR_W:0]   count_q, count_d, space;
  logic             enc_q, overflow_q;
  logic [4:0]       addrc_q;
  logic [31:0]      datac_q;

  logic             mem_ok, alu_ok, head_ok;
  logic             sel_valid, pop;
  logic [4:0]       sel_addr, pa_addr, pb_addr;
  logic [31:0]      sel_data, pa_data, pb_data;
  logic             pa_v, pb_v, acc_a, acc_b, drop;
  logic [1:0]       n_push;

  // Writes to r0 are architecturally void, so they never enter the arbiter.
  assign mem_ok  = mem_valid && (mem_addr != 5'd0);
  assign alu_ok  = alu_valid && (alu_addr != 5'd0);
  assign head_ok = (count_q != '0);

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    pop       = 1'b0;
    pa_v      = 1'b0;
    pa_addr   = '0;
    pa_data   = '0;
    pb_v      = 1'b0;
    pb_addr   = alu_addr;
    pb_data   = alu_data;
    if (head_ok) begin
      sel_valid = 1'b1;
      sel_addr  = fifo_addr_q[rd_ptr_q];
      sel_data  = fifo_data_q[rd_ptr_q];
      pop       = 1'b1;
      pa_v      = mem_ok || alu_ok;
      pa_addr   = mem_ok ? mem_addr : alu_addr;
      pa_data   = mem_ok ? mem_data : alu_data;
      pb_v      = mem_ok && alu_ok;
    end else if (mem_ok) begin
      sel_valid = 1'b1;
      sel_addr  = mem_addr;
      sel_data  = mem_data;
      pa_v      = alu_ok;
      pa_addr   = alu_addr;
      pa_data   = alu_data;
    end else if (alu_ok) begin
      sel_valid = 1'b1;
      sel_addr  = alu_addr;
      sel_data  = alu_data;
    end
  end

  // Pushes are accepted in age order, so the youngest (alu) item is the first to be dropped.
  assign space     = CntW'(DEPTH) - count_q + CntW'(pop);
  assign acc_a     = pa_v && (space != '0);
  assign acc_b     = pb_v && (space >= CntW'(2));
  assign drop      = (pa_v && !acc_a) || (pb_v && !acc_b);
  assign n_push    = {1'b0, acc_a} + {1'b0, acc_b};
  assign count_d   = count_q - CntW'(pop) + CntW'(n_push);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      enc_q      <= 1'b0;
      addrc_q    <= '0;
      datac_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q   <= wr_ptr_q + PTR_W'(n_push);
      count_q    <= count_d;
      enc_q      <= sel_valid;
      overflow_q <= overflow_q || drop;
      if (sel_valid) begin
        addrc_q <= sel_addr;
        datac_q <= sel_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (acc_a) begin
      fifo_addr_q[wr_ptr_q] <= pa_addr;
      fifo_data_q[wr_ptr_q] <= pa_data;
    end
    if (acc_b) begin
      fifo_addr_q[wr_ptr_p1] <= pb_addr;
      fifo_data_q[wr_ptr_p1] <= pb_data;
    end
  end

  // The committing write counts as pending: the bank returns the old value on that edge.
  always_comb begin
    logic [PTR_W-1:0] offset;
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        if (fifo_addr_q[i] == qa) pend_a = 1'b1;
        if (fifo_addr_q[i] == qb) pend_b = 1'b1;
      end
    end
    if ((mem_ok && mem_addr == qa) || (alu_ok && alu_addr == qa) || (enc_q && addrc_q == qa)) begin
      pend_a = 1'b1;
    end
    if ((mem_ok && mem_addr == qb) || (alu_ok && alu_addr == qb) || (enc_q && addrc_q == qb)) begin
      pend_b = 1'b1;
    end
    if (qa == 5'd0) pend_a = 1'b0;
    if (qb == 5'd0) pend_b = 1'b0;
  end

  assign enc      = enc_q;
  assign addrc    = addrc_q;
  assign datac    = datac_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign stall    = (count_q >= CntW'(DEPTH - 1));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected commits go to a scoreboard queue,
// a negedge monitor checks every enc pulse against it.
module tb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_addr, mem_addr, qa, qb;
  logic [31:0] alu_data, mem_data;
  logic        enc, pend_a, pend_b, stall, overflow;
  logic [4:0]  addrc;
  logic [31:0] datac;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];

  writeback_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .qa(qa), .qb(qb),
    .enc(enc), .addrc(addrc), .datac(datac),
    .pend_a(pend_a), .pend_b(pend_b), .stall(stall),
    .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  // Monitor: every commit must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (enc !== 1'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL commit_unexpected: got enc=%b addrc=%0d datac=%08h, required no commit",
                 enc, addrc, datac);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (enc !== 1'b1 || addrc !== e.a || datac !== e.d) begin
          n_bad++;
          $display("FAIL commit_order: got addrc=%0d datac=%08h, required addrc=%0d datac=%08h",
                   addrc, datac, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    qa = '0;
    qb = '0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    step();
    step();
    chk("reset_enc", 32'(enc), 32'd0);
    chk("reset_addrc", 32'(addrc), 32'd0);
    chk("reset_datac", datac, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    // Single ALU write: one-cycle latency, then enc drops and addr/data hold.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_00AA);
    expect_wr(5'd5, 32'hAA);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("single_enc", 32'(enc), 32'd1);
    chk("single_addrc", 32'(addrc), 32'd5);
    chk("single_datac", datac, 32'hAA);
    step();
    chk("single_enc_drop", 32'(enc), 32'd0);
    chk("single_addrc_hold", 32'(addrc), 32'd5);

    // Collision on r3: mem first, then alu; pending until the second commit retires.
    qa = 5'd3;
    drive(1'b1, 5'd3, 32'h111, 1'b1, 5'd3, 32'h222);
    expect_wr(5'd3, 32'h111);
    expect_wr(5'd3, 32'h222);
    #1 chk("coll_pend_in", 32'(pend_a), 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("coll_count1", 32'(count), 32'd1);
    chk("coll_pend_c1", 32'(pend_a), 32'd1);
    step();
    chk("coll_count0", 32'(count), 32'd0);
    chk("coll_pend_c2", 32'(pend_a), 32'd1);
    step();
    chk("coll_pend_after", 32'(pend_a), 32'd0);

    // r0 writes vanish; qa=0 never reports pending.
    qa = 5'd0;
    qb = 5'd7;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd7, 32'h7);
    expect_wr(5'd7, 32'h7);
    #1;
    chk("zero_pend_a", 32'(pend_a), 32'd0);
    chk("zero_pend_b", 32'(pend_b), 32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("zero_count", 32'(count), 32'd0);
    chk("zero_pend_a_c", 32'(pend_a), 32'd0);
    step();

    // Fill to three entries, stall at 3, then drain in FIFO order.
    qb = 5'd22;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(10 + k), 32'h100 + 32'(k), 1'b1, 5'(20 + k), 32'h200 + 32'(k));
      expect_wr(5'(10 + k), 32'h100 + 32'(k));
      expect_wr(5'(20 + k), 32'h200 + 32'(k));
      step();
      chk("fill_count", 32'(count), 32'(k + 1));
      chk("fill_stall", 32'(stall), (k == 2) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 chk("fill_pend_fifo", 32'(pend_b), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drain_count", 32'(count), 32'(2 - k));
    end
    step();
    chk("drain_enc_off", 32'(enc), 32'd0);

    // Keep issuing through stall: the fifth dual request overflows and loses its alu item.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(1 + k), 32'h300 + 32'(k), 1'b1, 5'(11 + k), 32'h400 + 32'(k));
      expect_wr(5'(1 + k), 32'h300 + 32'(k));
      if (k != 4) expect_wr(5'(11 + k), 32'h400 + 32'(k));
      step();
      chk("ovf_count", 32'(count), (k >= 3) ? 32'd4 : 32'(k + 1));
      chk("ovf_flag", 32'(overflow), (k == 4) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_drain_count", 32'(count), 32'd3);

    // Reset mid-drain discards the buffered writes.
    reset = 1'b1;
    step();
    exp_q.delete();
    chk("rst_mid_enc", 32'(enc), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_no_commit", 32'(enc), 32'd0);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
